reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer for the out-of-order core. Sits between the Dispatcher/CDB and the register file.
- Allocates one entry per dispatched instruction and captures results from the CDB.
- Retires at most one entry per cycle in program order, driving the register file update bus.
- On a mispredicted branch at commit, raises a one-cycle flush with the corrected PC.

Parameters:
- RoB_WIDTH, 3, log2 of entry count (SIZE = 1 << RoB_WIDTH = 8).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  low = pause; all state held.
- issue_en  input  1  allocate entry at tail this cycle.
- issue_type  input  2  0 = REG write, 1 = STORE, 2 = BRANCH.
- issue_rd  input  5  destination register (REG only).
- issue_pred_taken  input  1  predicted direction (BRANCH only).
- issue_alt_pc  input  32  PC of the non-predicted path (BRANCH only).
- issue_index  output  RoB_WIDTH  current tail; combinational.
- full  output  1  count == SIZE; combinational.
- cdb_en  input  1  result broadcast valid.
- cdb_index  input  RoB_WIDTH  producing entry.
- cdb_value  input  32  result; for BRANCH, bit0 = actual taken.
- query_idx1, query_idx2  input  RoB_WIDTH  Dispatcher operand lookup.
- query_ready1, query_ready2  output  1  entry holds a result (combinational; includes same-cycle CDB hit).
- query_value1, query_value2  output  32  entry value or same-cycle cdb_value.
- commit_reg_en  output  1  register file update pulse.
- commit_reg  output  6  bit5 = 1 means no register; else bits[4:0] = rd.
- commit_index  output  RoB_WIDTH  retiring entry.
- commit_data  output  32  retiring value.
- store_commit_en  output  1  head STORE retired; LSB may write memory.
- flush_signal  output  1  one-cycle flush pulse.
- flush_pc  output  32  redirect target.
- retired_count  output  32  see Optional Feature.

Behaviour:
- Storage per entry: busy, ready, type, rd, pred_taken, alt_pc, value. Pointers: head, tail (RoB_WIDTH bits, natural wrap). Counter: count (RoB_WIDTH+1 bits).
- Reset (sync, rst_in=1):
  - all entries not busy; head = tail = count = 0.
  - All registered outputs 0, except commit_reg = 6'b100000.
- rdy_in=0: no state change; pulse outputs (commit_reg_en, store_commit_en, flush_signal) driven 0 next edge.
- Issue:
  - issue_en && !full: entry[tail] set busy, ready = (type == STORE), fields captured; tail++.
  - issue_en while full: ignored. full uses pre-edge count, so a same-cycle commit does not free a slot for that issue.
- CDB: cdb_en writes value and sets ready on entry[cdb_index] if busy. A write to a non-busy entry is ignored.
- Commit (registered, one per edge): if entry[head] is busy && ready at posedge, then next cycle:
  - REG:
    - rd != 0: commit_reg_en = 1, commit_reg = {0, rd}, commit_index = head, commit_data = value.
    - rd == 0: retire with commit_reg_en = 0.
  - STORE: store_commit_en = 1, commit_index = head.
  - BRANCH:
    - value[0] == pred_taken: retire silently.
    - otherwise: flush_signal = 1, flush_pc = alt_pc.
  - head++, count--. Pulses last exactly one cycle.
- Latency: a CDB write to the head at edge N makes the entry ready; commit occurs at edge N+1; outputs are visible after N+1.
- Flush:
  - At the edge that asserts flush_signal, all entries are cleared and head = tail = count = 0.
  - Issue and CDB in the same cycle are discarded.
  - While flush_signal=1, issue and CDB inputs are ignored.
  - The flushing branch itself does not drive commit_reg_en.
- Simultaneous events:
  - Issue + commit in the same cycle (not full): count unchanged.
  - CDB to an entry issued in the same cycle: ignored (entry not yet busy).
- Query:
  - Priority: same-cycle CDB match first, then stored ready value.
  - Non-busy entry: ready = 0, value = 0.

Optional Feature:
- ROB_RETIRE_CNT_EN:
  - Defined: retired_count increments on every retirement (including silent ones and the flushing branch); reset to 0; not cleared by flush.
  - Undefined: retired_count tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, issue REG rd=5, CDB value 0x1234 → next edge commit_reg_en=1, commit_reg=6'b000101, commit_data=0x1234, commit_index=0.
- Issue 8 entries → full=1, issue_index=0 (wrapped); 9th issue ignored. Complete entry 0 → after commit, full=0, issue_index=0.
- Issue BRANCH pred_taken=0, alt_pc=0x80, CDB value bit0=1 → flush_signal=1 for one cycle, flush_pc=0x80. Next cycle count=0, issue_index=0, younger ready entries never commit.
- Out-of-order CDB (entry 1 ready before entry 0) → no commit until entry 0 ready; then commits 0 and 1 on consecutive cycles.
- Query entry 2 while cdb_en targets entry 2 with 0xBEEF → query_ready=1, query_value=0xBEEF the same cycle.
- rdy_in=0 for 3 cycles with ready head → no commit pulses; commit occurs at the first edge after rdy_in returns to 1.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Bus bundle between the Dispatcher/CDB side (master) and the reorder buffer (slave).
// Carries issue, CDB broadcast, operand query, commit and flush signals.
interface reorder_buffer_if #(
  parameter int RoB_WIDTH = 3
);
  logic                 issue_en;
  logic [1:0]           issue_type;
  logic [4:0]           issue_rd;
  logic                 issue_pred_taken;
  logic [31:0]          issue_alt_pc;
  logic [RoB_WIDTH-1:0] issue_index;
  logic                 full;

  logic                 cdb_en;
  logic [RoB_WIDTH-1:0] cdb_index;
  logic [31:0]          cdb_value;

  logic [RoB_WIDTH-1:0] query_idx1;
  logic [RoB_WIDTH-1:0] query_idx2;
  logic                 query_ready1;
  logic                 query_ready2;
  logic [31:0]          query_value1;
  logic [31:0]          query_value2;

  logic                 commit_reg_en;
  logic [5:0]           commit_reg;
  logic [RoB_WIDTH-1:0] commit_index;
  logic [31:0]          commit_data;
  logic                 store_commit_en;
  logic                 flush_signal;
  logic [31:0]          flush_pc;
  logic [31:0]          retired_count;

  modport master (
    output issue_en, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    output cdb_en, cdb_index, cdb_value, query_idx1, query_idx2,
    input  issue_index, full, query_ready1, query_ready2, query_value1, query_value2,
    input  commit_reg_en, commit_reg, commit_index, commit_data, store_commit_en,
    input  flush_signal, flush_pc, retired_count
  );

  modport slave (
    input  issue_en, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    input  cdb_en, cdb_index, cdb_value, query_idx1, query_idx2,
    output issue_index, full, query_ready1, query_ready2, query_value1, query_value2,
    output commit_reg_en, commit_reg, commit_index, commit_data, store_commit_en,
    output flush_signal, flush_pc, retired_count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retirement of out-of-order results, with branch flush.
// Define ROB_RETIRE_CNT_EN to build the retirement counter on retired_count.
module reorder_buffer #(
  parameter int RoB_WIDTH = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  rob
);
  localparam int SIZE = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0] SIZE_CNT = (RoB_WIDTH + 1)'(SIZE);

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2,
    TYPE_RSVD   = 2'd3
  } entry_type_e;

  logic [SIZE-1:0]      busy_reg;
  logic [SIZE-1:0]      ready_reg;
  entry_type_e          type_mem   [SIZE];
  logic [4:0]           rd_mem     [SIZE];
  logic                 pred_mem   [SIZE];
  logic [31:0]          alt_pc_mem [SIZE];
  logic [31:0]          value_mem  [SIZE];

  logic [RoB_WIDTH-1:0] head_reg;
  logic [RoB_WIDTH-1:0] tail_reg;
  logic [RoB_WIDTH:0]   count_reg;

  logic                 commit_reg_en_reg;
  logic [5:0]           commit_reg_reg;
  logic [RoB_WIDTH-1:0] commit_index_reg;
  logic [31:0]          commit_data_reg;
  logic                 store_commit_en_reg;
  logic                 flush_reg;
  logic [31:0]          flush_pc_reg;

  logic full_w;
  logic issue_fire;
  logic cdb_fire;
  logic head_done;
  logic head_mispredict;

  assign full_w     = (count_reg == SIZE_CNT);
  // Nothing is accepted during the flush pulse; the buffer has just been emptied.
  assign issue_fire = rob.issue_en && !full_w && !flush_reg;
  assign cdb_fire   = rob.cdb_en && !flush_reg;
  assign head_done  = busy_reg[head_reg] && ready_reg[head_reg];
  assign head_mispredict = head_done && (type_mem[head_reg] == TYPE_BRANCH) &&
                           (value_mem[head_reg][0] != pred_mem[head_reg]);

  logic [SIZE-1:0] issue_hit;
  logic [SIZE-1:0] cdb_hit;
  logic [SIZE-1:0] retire_hit;

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_entry_hit
    assign issue_hit[gi]  = issue_fire && (tail_reg == RoB_WIDTH'(gi));
    assign cdb_hit[gi]    = cdb_fire && busy_reg[gi] && (rob.cdb_index == RoB_WIDTH'(gi));
    assign retire_hit[gi] = head_done && (head_reg == RoB_WIDTH'(gi));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_reg  <= '0;
      ready_reg <= '0;
    end else if (rdy_in) begin
      if (head_mispredict) begin
        busy_reg  <= '0;
        ready_reg <= '0;
      end else begin
        for (int i = 0; i < SIZE; i++) begin
          if (cdb_hit[i]) begin
            ready_reg[i] <= 1'b1;
          end
          if (retire_hit[i]) begin
            busy_reg[i]  <= 1'b0;
            ready_reg[i] <= 1'b0;
          end
          if (issue_hit[i]) begin
            busy_reg[i]  <= 1'b1;
            ready_reg[i] <= (rob.issue_type == TYPE_STORE);
          end
        end
      end
    end
  end

  // Payload needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < SIZE; i++) begin
        if (cdb_hit[i]) begin
          value_mem[i] <= rob.cdb_value;
        end
        if (issue_hit[i]) begin
          type_mem[i]   <= entry_type_e'(rob.issue_type);
          rd_mem[i]     <= rob.issue_rd;
          pred_mem[i]   <= rob.issue_pred_taken;
          alt_pc_mem[i] <= rob.issue_alt_pc;
          value_mem[i]  <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy_in) begin
      if (head_mispredict) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        head_reg  <= head_reg + RoB_WIDTH'(head_done);
        tail_reg  <= tail_reg + RoB_WIDTH'(issue_fire);
        count_reg <= count_reg + (RoB_WIDTH + 1)'(issue_fire) - (RoB_WIDTH + 1)'(head_done);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      commit_reg_en_reg   <= 1'b0;
      commit_reg_reg      <= 6'b100000;
      commit_index_reg    <= '0;
      commit_data_reg     <= '0;
      store_commit_en_reg <= 1'b0;
      flush_reg           <= 1'b0;
      flush_pc_reg        <= '0;
    end else if (!rdy_in) begin
      commit_reg_en_reg   <= 1'b0;
      store_commit_en_reg <= 1'b0;
      flush_reg           <= 1'b0;
    end else begin
      commit_reg_en_reg   <= 1'b0;
      store_commit_en_reg <= 1'b0;
      flush_reg           <= head_mispredict;
      if (head_done) begin
        commit_index_reg <= head_reg;
        case (type_mem[head_reg])
          TYPE_REG: begin
            if (rd_mem[head_reg] != 5'd0) begin
              commit_reg_en_reg <= 1'b1;
              commit_reg_reg    <= {1'b0, rd_mem[head_reg]};
              commit_data_reg   <= value_mem[head_reg];
            end
          end
          TYPE_STORE:  store_commit_en_reg <= 1'b1;
          TYPE_BRANCH: begin
            if (head_mispredict) begin
              flush_pc_reg <= alt_pc_mem[head_reg];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Same-cycle CDB broadcast wins over the stored value.
  function automatic logic [32:0] query_lookup(input logic [RoB_WIDTH-1:0] idx);
    logic [32:0] res;
    res = '0;
    if (cdb_fire && busy_reg[idx] && (rob.cdb_index == idx)) begin
      res = {1'b1, rob.cdb_value};
    end else if (busy_reg[idx] && ready_reg[idx]) begin
      res = {1'b1, value_mem[idx]};
    end
    return res;
  endfunction

  assign {rob.query_ready1, rob.query_value1} = query_lookup(rob.query_idx1);
  assign {rob.query_ready2, rob.query_value2} = query_lookup(rob.query_idx2);

  assign rob.issue_index     = tail_reg;
  assign rob.full            = full_w;
  assign rob.commit_reg_en   = commit_reg_en_reg;
  assign rob.commit_reg      = commit_reg_reg;
  assign rob.commit_index    = commit_index_reg;
  assign rob.commit_data     = commit_data_reg;
  assign rob.store_commit_en = store_commit_en_reg;
  assign rob.flush_signal    = flush_reg;
  assign rob.flush_pc        = flush_pc_reg;

`ifdef ROB_RETIRE_CNT_EN
  logic [31:0] retired_count_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      retired_count_reg <= '0;
    end else if (rdy_in && head_done) begin
      retired_count_reg <= retired_count_reg + 32'd1;
    end
  end

  assign rob.retired_count = retired_count_reg;
`else
  assign rob.retired_count = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected retirements, a monitor checks them.
module tb_reorder_buffer;
  localparam int W = 3;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  reorder_buffer_if #(.RoB_WIDTH(W)) rob_bus ();

  reorder_buffer #(.RoB_WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rob    (rob_bus)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // kind: 0 = register commit, 1 = store commit, 2 = flush (data holds flush_pc)
  typedef struct {
    int         kind;
    logic [2:0] idx;
    logic [5:0] rg;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int kind, input logic [2:0] idx, input logic [5:0] rg,
                          input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.rg   = rg;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int   act_kind;
    int   n_pulse;
    forever begin
      @(negedge clk_in);
      if (rob_bus.commit_reg_en || rob_bus.store_commit_en || rob_bus.flush_signal) begin
        n_pulse  = int'(rob_bus.commit_reg_en) + int'(rob_bus.store_commit_en) +
                   int'(rob_bus.flush_signal);
        act_kind = rob_bus.flush_signal ? 2 : (rob_bus.store_commit_en ? 1 : 0);
        $display("retire kind=%0d idx=%0d reg=0x%0h data=0x%0h flush_pc=0x%0h", act_kind,
                 rob_bus.commit_index, rob_bus.commit_reg, rob_bus.commit_data, rob_bus.flush_pc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: actual kind=%0d idx=%0d required none", act_kind,
                   rob_bus.commit_index);
        end else begin
          e = exp_q.pop_front();
          check32("pulse_onehot", n_pulse, 1);
          check32("retire_kind", act_kind, e.kind);
          if (e.kind == 2) begin
            check32("flush_pc", rob_bus.flush_pc, e.data);
          end else begin
            check32("commit_index", rob_bus.commit_index, e.idx);
            if (e.kind == 0) begin
              check32("commit_reg", rob_bus.commit_reg, e.rg);
              check32("commit_data", rob_bus.commit_data, e.data);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                       input logic [31:0] alt);
    rob_bus.issue_en         = 1'b1;
    rob_bus.issue_type       = t;
    rob_bus.issue_rd         = rd;
    rob_bus.issue_pred_taken = pred;
    rob_bus.issue_alt_pc     = alt;
    tick();
    rob_bus.issue_en = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] idx, input logic [31:0] val);
    rob_bus.cdb_en    = 1'b1;
    rob_bus.cdb_index = idx;
    rob_bus.cdb_value = val;
    tick();
    rob_bus.cdb_en = 1'b0;
  endtask

  initial begin : stimulus
    rst_in                   = 1'b1;
    rdy_in                   = 1'b1;
    rob_bus.issue_en         = 1'b0;
    rob_bus.issue_type       = 2'd0;
    rob_bus.issue_rd         = 5'd0;
    rob_bus.issue_pred_taken = 1'b0;
    rob_bus.issue_alt_pc     = 32'd0;
    rob_bus.cdb_en           = 1'b0;
    rob_bus.cdb_index        = 3'd0;
    rob_bus.cdb_value        = 32'd0;
    rob_bus.query_idx1       = 3'd0;
    rob_bus.query_idx2       = 3'd0;

    // Reset state and a single register commit
    do_reset();
    check32("rst_commit_reg", rob_bus.commit_reg, 32'h20);
    check32("rst_commit_reg_en", rob_bus.commit_reg_en, 0);
    check32("rst_store_en", rob_bus.store_commit_en, 0);
    check32("rst_flush", rob_bus.flush_signal, 0);
    check32("rst_flush_pc", rob_bus.flush_pc, 0);
    check32("rst_commit_data", rob_bus.commit_data, 0);
    check32("rst_full", rob_bus.full, 0);
    check32("rst_issue_index", rob_bus.issue_index, 0);
    check32("rst_retired_count", rob_bus.retired_count, 0);
    issue(2'd0, 5'd5, 1'b0, 32'd0);
    check32("t1_issue_index", rob_bus.issue_index, 1);
    push_exp(0, 3'd0, 6'b000101, 32'h1234);
    cdb(3'd0, 32'h1234);
    tick();
    check32("t1_commit_latency", rob_bus.commit_reg_en, 1);
    tick();
    check32("t1_pulse_one_cycle", rob_bus.commit_reg_en, 0);

    // Fill to full, blocked 9th issue, then free one slot
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(2'd0, 5'(i + 1), 1'b0, 32'd0);
    end
    check32("t2_full", rob_bus.full, 1);
    check32("t2_index_wrapped", rob_bus.issue_index, 0);
    issue(2'd0, 5'd20, 1'b0, 32'd0);
    check32("t2_9th_ignored_index", rob_bus.issue_index, 0);
    check32("t2_9th_still_full", rob_bus.full, 1);
    push_exp(0, 3'd0, 6'd1, 32'hA0);
    cdb(3'd0, 32'hA0);
    check32("t2_full_before_commit", rob_bus.full, 1);
    tick();
    check32("t2_full_after_commit", rob_bus.full, 0);
    check32("t2_index_after_commit", rob_bus.issue_index, 0);
    tick();

    // Mispredicted branch flush with a younger ready entry
    do_reset();
    issue(2'd2, 5'd0, 1'b0, 32'h80);
    issue(2'd0, 5'd3, 1'b0, 32'd0);
    cdb(3'd1, 32'h55);
    push_exp(2, 3'd0, 6'd0, 32'h80);
    cdb(3'd0, 32'h1);
    rob_bus.issue_en   = 1'b1;
    rob_bus.issue_type = 2'd0;
    rob_bus.issue_rd   = 5'd7;
    tick();
    check32("t3_flush_signal", rob_bus.flush_signal, 1);
    check32("t3_flush_pc", rob_bus.flush_pc, 32'h80);
    check32("t3_flush_no_reg_en", rob_bus.commit_reg_en, 0);
    check32("t3_index_at_flush", rob_bus.issue_index, 0);
    tick();
    rob_bus.issue_en = 1'b0;
    check32("t3_flush_one_cycle", rob_bus.flush_signal, 0);
    check32("t3_index_after_flush", rob_bus.issue_index, 0);
    check32("t3_full_after_flush", rob_bus.full, 0);
    rob_bus.query_idx1 = 3'd1;
    #1;
    check32("t3_young_cleared", rob_bus.query_ready1, 0);
    for (int i = 0; i < 4; i++) tick();

    // Out-of-order completion, silent rd=0 retire, store retire
    do_reset();
    issue(2'd0, 5'd10, 1'b0, 32'd0);
    issue(2'd0, 5'd11, 1'b0, 32'd0);
    issue(2'd0, 5'd0, 1'b0, 32'd0);
    issue(2'd1, 5'd0, 1'b0, 32'd0);
    cdb(3'd1, 32'h1111);
    tick();
    tick();
    check32("t4_stalled", rob_bus.commit_reg_en, 0);
    push_exp(0, 3'd0, 6'd10, 32'h2222);
    push_exp(0, 3'd1, 6'd11, 32'h1111);
    cdb(3'd0, 32'h2222);
    tick();
    check32("t4_first_en", rob_bus.commit_reg_en, 1);
    check32("t4_first_index", rob_bus.commit_index, 0);
    tick();
    check32("t4_second_en", rob_bus.commit_reg_en, 1);
    check32("t4_second_index", rob_bus.commit_index, 1);
    push_exp(1, 3'd3, 6'd0, 32'd0);
    cdb(3'd2, 32'h3333);
    tick();
    check32("t4_rd0_silent", rob_bus.commit_reg_en, 0);
    tick();
    check32("t4_store_en", rob_bus.store_commit_en, 1);
    tick();
`ifdef ROB_RETIRE_CNT_EN
    check32("t4_retired_count", rob_bus.retired_count, 4);
`else
    check32("t4_retired_count", rob_bus.retired_count, 0);
`endif
    check32("t4_index_end", rob_bus.issue_index, 4);

    // Query forwarding from the CDB and from storage
    do_reset();
    issue(2'd0, 5'd1, 1'b0, 32'd0);
    issue(2'd0, 5'd2, 1'b0, 32'd0);
    issue(2'd0, 5'd3, 1'b0, 32'd0);
    rob_bus.query_idx1 = 3'd2;
    rob_bus.query_idx2 = 3'd1;
    rob_bus.cdb_en     = 1'b1;
    rob_bus.cdb_index  = 3'd2;
    rob_bus.cdb_value  = 32'hBEEF;
    #1;
    check32("t5_fwd_ready", rob_bus.query_ready1, 1);
    check32("t5_fwd_value", rob_bus.query_value1, 32'hBEEF);
    check32("t5_other_ready", rob_bus.query_ready2, 0);
    check32("t5_other_value", rob_bus.query_value2, 0);
    tick();
    rob_bus.cdb_en = 1'b0;
    #1;
    check32("t5_stored_ready", rob_bus.query_ready1, 1);
    check32("t5_stored_value", rob_bus.query_value1, 32'hBEEF);
    cdb(3'd6, 32'h777);
    rob_bus.query_idx2 = 3'd6;
    #1;
    check32("t5_nonbusy_ready", rob_bus.query_ready2, 0);
    check32("t5_nonbusy_value", rob_bus.query_value2, 0);

    // Pause with a ready head
    do_reset();
    issue(2'd0, 5'd9, 1'b0, 32'd0);
    rob_bus.cdb_en    = 1'b1;
    rob_bus.cdb_index = 3'd0;
    rob_bus.cdb_value = 32'h99;
    tick();
    rob_bus.cdb_en = 1'b0;
    rdy_in         = 1'b0;
    push_exp(0, 3'd0, 6'd9, 32'h99);
    for (int k = 0; k < 3; k++) begin
      tick();
      check32("t6_paused", rob_bus.commit_reg_en, 0);
    end
    rdy_in = 1'b1;
    tick();
    check32("t6_resume_en", rob_bus.commit_reg_en, 1);
    check32("t6_resume_data", rob_bus.commit_data, 32'h99);
    tick();
    tick();

    check32("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
